// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB encodings and slave FSM state type shared by the memory slave
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // True when the transfer size is supported and the low address bits are aligned to it
  function automatic logic size_ok(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return !lo[0];
      HSIZE_WORD: return lo == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_excl_monitor.sv
// rtl/ahb_excl_monitor.sv - single-entry exclusive-access reservation for the AHB memory slave
module ahb_excl_monitor #(
  parameter int AW = 8
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic [AW-1:0] addr,
  input  logic          set_resv,
  input  logic          write_done,
  output logic          hit
);

  logic          valid_q;
  logic [AW-1:0] resv_q;

  assign hit = valid_q && (resv_q == addr);

  // A completed write to the reserved word drops the reservation; an exclusive read takes it
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      valid_q <= 1'b0;
      resv_q  <= '0;
    end else if (write_done && hit) begin
      valid_q <= 1'b0;
    end else if (set_resv) begin
      valid_q <= 1'b1;
      resv_q  <= addr;
    end
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB word memory slave with wait states; AHB_SLV_EXCL_EN adds an exclusive monitor
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [6:0]  hprot,
  input  logic        hnonsec,
  input  logic        hexcl,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hexokay
);

  localparam int          IDXW  = $clog2(MEM_DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEM_DEPTH);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      lane_q;
  logic [1:0]      size_q;
  logic            write_q;

  logic [31:0]     off;
  logic            accept;
  logic            legal;
  logic            complete;
  logic            write_ok;
  logic            mem_we;
  logic [3:0]      be;
  logic [31:0]     mem [MEM_DEPTH];

  assign off    = haddr - BASE_ADDR;
  assign accept = hsel && hready && (state_q == ST_IDLE || state_q == ST_ERR2) &&
                  (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign legal  = ({1'b0, haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, haddr} < LIMIT) &&
                  size_ok(hsize, haddr[1:0]);

  // The data phase of a legal transfer finishes in IDLE with the pending flag set
  assign complete = (state_q == ST_IDLE) && pend_q;
  assign mem_we   = complete && write_q && write_ok;
  assign hrdata   = (complete && !write_q) ? mem[idx_q] : 32'h0;

  // FSM, wait counter and pending-completion registers
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and the handshake outputs; a new address phase may overlap IDLE or ERR2
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = 1'b0;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          pend_d  = 1'b1;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (!legal) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES == 0) begin
        state_d = ST_IDLE;
        pend_d  = 1'b1;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = 3'(WAIT_STATES);
      end
    end
  end

  // Capture the address-phase controls for the following data phase
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= off[IDXW+1:2];
      lane_q  <= off[1:0];
      size_q  <= hsize[1:0];
      write_q <= hwrite;
    end
  end

  // Little-endian byte-lane enables from the registered size and low address bits
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'b00:   be = 4'b0001 << lane_q;
      2'b01:   be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory array keeps its contents across reset; writes land at the end of the completion cycle
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  logic unused_off;
  assign unused_off = &{1'b0, off[31:IDXW+2]};

`ifdef AHB_SLV_EXCL_EN
  logic excl_q;
  logic resv_hit;

  // Exclusive flag travels with the address phase
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) excl_q <= 1'b0;
    else if (accept) excl_q <= hexcl;
  end

  ahb_excl_monitor #(.AW(IDXW)) u_excl (
    .hclk       (hclk),
    .hrst       (hrst),
    .addr       (idx_q),
    .set_resv   (complete && !write_q && excl_q),
    .write_done (complete && write_q),
    .hit        (resv_hit)
  );

  assign write_ok = !excl_q || resv_hit;
  assign hexokay  = complete && write_q && excl_q && resv_hit;

  logic unused_in;
  assign unused_in = &{1'b0, hburst, hprot, hnonsec};
`else
  assign write_ok = 1'b1;
  assign hexokay  = 1'b0;

  logic unused_in;
  assign unused_in = &{1'b0, hburst, hprot, hnonsec, hexcl};
`endif

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem (WAIT_STATES=2 and WAIT_STATES=0 instances)
module tb_ahb_slave_mem;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    logic        exok;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic        hclk = 1'b0;
  logic        hrst = 1'b0;

  logic        hsel = 1'b0, hwrite = 1'b0, hexcl = 1'b0, ext_lo = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic        hready, hreadyout, hexokay;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  logic        sel0 = 1'b0, write0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [1:0]  trans0 = 2'b00;
  logic        ready0, exok0;
  logic [31:0] rdata0;
  logic [1:0]  resp0;

  exp_t        sb[$];
  logic [31:0] sb0[$];
  logic [31:0] model [int];
  logic        rv_valid = 1'b0;
  logic [31:0] rv_addr = '0;

  assign hready = hreadyout & ~ext_lo;

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'b000), .hprot(7'h03), .hnonsec(1'b0), .hexcl(hexcl),
    .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hrdata(hrdata),
    .hresp(hresp), .hexokay(hexokay)
  );

  ahb_slave_mem #(.MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hrst(hrst), .hsel(sel0), .haddr(addr0), .htrans(trans0), .hwrite(write0),
    .hsize(3'b010), .hburst(3'b000), .hprot(7'h03), .hnonsec(1'b0), .hexcl(1'b0),
    .hwdata(wdata0), .hready(ready0), .hreadyout(ready0), .hrdata(rdata0),
    .hresp(resp0), .hexokay(exok0)
  );

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [1:0] lane, logic [2:0] sz);
    logic [31:0] r;
    r = old;
    if (sz == 3'd0) r[8*lane +: 8] = d[8*lane +: 8];
    else if (sz == 3'd1) r[16*lane[1] +: 16] = d[16*lane[1] +: 16];
    else r = d;
    return r;
  endfunction

  // One transfer on the WAIT_STATES=2 instance: expectation pushed at the address phase, popped at completion
  task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] d, input logic ex);
    exp_t e, got;
    int waits;
    logic ok;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    e.rd = !wr;
    e.err = (a >= 32'h400) || (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
    e.data = model.exists(int'(wa)) ? model[int'(wa)] : 32'h0;
    e.exok = 1'b0;
    if (!e.err && wr) begin
      ok = 1'b1;
`ifdef AHB_SLV_EXCL_EN
      if (ex) begin
        ok = rv_valid && rv_addr == wa;
        e.exok = ok;
      end
      if (rv_valid && rv_addr == wa) rv_valid = 1'b0;
`endif
      if (ok) model[int'(wa)] = merge(e.data, d, a[1:0], sz);
    end
`ifdef AHB_SLV_EXCL_EN
    if (!e.err && !wr && ex) begin
      rv_valid = 1'b1;
      rv_addr = wa;
    end
`endif
    sb.push_back(e);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hexcl = ex;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = d; hexcl = 1'b0;
    waits = 0;
    forever begin
      @(negedge hclk);
      if (hreadyout === 1'b1 || waits > 15) break;
      waits++;
      n_cmp++;
      if (hresp !== (e.err ? 2'b01 : 2'b00)) begin
        n_bad++; $display("FAIL wait_resp addr=%h got %b want %b", a, hresp, e.err ? 2'b01 : 2'b00);
      end
    end
    got = sb.pop_front();
    n_cmp++;
    if (waits !== (got.err ? 1 : 2)) begin
      n_bad++; $display("FAIL wait_count addr=%h got %0d want %0d", a, waits, got.err ? 1 : 2);
    end
    n_cmp++;
    if (hresp !== (got.err ? 2'b01 : 2'b00)) begin
      n_bad++; $display("FAIL done_resp addr=%h got %b want %b", a, hresp, got.err ? 2'b01 : 2'b00);
    end
    if (got.rd && !got.err) begin
      n_cmp++;
      if (hrdata !== got.data) begin
        n_bad++; $display("FAIL rdata addr=%h got %h want %h", a, hrdata, got.data);
      end
    end
    if (!got.rd && !got.err) begin
      n_cmp++;
      if (hexokay !== got.exok) begin
        n_bad++; $display("FAIL hexokay addr=%h got %b want %b", a, hexokay, got.exok);
      end
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge hclk);
    #1;
    n_cmp++; if (hreadyout !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", hreadyout); end
    n_cmp++; if (hresp !== 2'b00) begin n_bad++; $display("FAIL rst_resp got %b want 00", hresp); end
    n_cmp++; if (hrdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", hrdata); end
    n_cmp++; if (hexokay !== 1'b0) begin n_bad++; $display("FAIL rst_exok got %b want 0", hexokay); end
    n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL rst_ready0 got %b want 1", ready0); end
    hrst = 1'b1;
  endtask

  task automatic test_word_rw();
    do_xfer(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
    do_xfer(1'b1, 32'h3FC, 3'd2, 32'hCAFE_0001, 1'b0);
    do_xfer(1'b0, 32'h3FC, 3'd2, 32'h0, 1'b0);
  endtask

  task automatic test_byte_half();
    do_xfer(1'b1, 32'h10, 3'd2, 32'h0, 1'b0);
    do_xfer(1'b1, 32'h13, 3'd0, 32'hA500_0000, 1'b0);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
    n_cmp++;
    if (model[32'h10] !== 32'hA500_0000) begin n_bad++; $display("FAIL byte_model got %h want a5000000", model[32'h10]); end
    do_xfer(1'b1, 32'h14, 3'd2, 32'h1111_1111, 1'b0);
    do_xfer(1'b1, 32'h16, 3'd1, 32'hBEEF_0000, 1'b0);
    do_xfer(1'b1, 32'h15, 3'd0, 32'h0000_7700, 1'b0);
    do_xfer(1'b0, 32'h14, 3'd2, 32'h0, 1'b0);
  endtask

  task automatic test_idle_busy();
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b10; hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    n_cmp++; if (hreadyout !== 1'b1 || hresp !== 2'b00) begin n_bad++; $display("FAIL busy_resp got %b/%b want 1/00", hreadyout, hresp); end
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(negedge hclk);
    n_cmp++; if (hreadyout !== 1'b1 || hrdata !== 32'h0) begin n_bad++; $display("FAIL unsel_resp got %b/%h want 1/0", hreadyout, hrdata); end
    @(posedge hclk); #1;
  endtask

  task automatic test_illegal();
    do_xfer(1'b0, 32'h400, 3'd2, 32'h0, 1'b0);
    do_xfer(1'b0, 32'h11, 3'd1, 32'h0, 1'b0);
    do_xfer(1'b0, 32'h10, 3'd3, 32'h0, 1'b0);
    do_xfer(1'b1, 32'h12, 3'd2, 32'hFFFF_FFFF, 1'b0);
    do_xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
  endtask

  task automatic test_hready_low();
    do_xfer(1'b1, 32'h30, 3'd2, 32'h0BAD_F00D, 1'b0);
    ext_lo = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    ext_lo = 1'b0; hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    n_cmp++; if (hreadyout !== 1'b1) begin n_bad++; $display("FAIL hready_low_ignored got %b want 1", hreadyout); end
    @(posedge hclk); #1;
    do_xfer(1'b0, 32'h30, 3'd2, 32'h0, 1'b0);
  endtask

  task automatic test_reset_abort();
    do_xfer(1'b1, 32'h20, 3'd2, 32'h1111_2222, 1'b0);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h3333_4444;
    @(negedge hclk);
    n_cmp++; if (hreadyout !== 1'b0) begin n_bad++; $display("FAIL abort_wait got %b want 0", hreadyout); end
    #1 hrst = 1'b0;
    #1;
    n_cmp++; if (hreadyout !== 1'b1 || hresp !== 2'b00) begin n_bad++; $display("FAIL abort_ready got %b/%b want 1/00", hreadyout, hresp); end
    @(posedge hclk); #1;
    hrst = 1'b1;
    do_xfer(1'b0, 32'h20, 3'd2, 32'h0, 1'b0);
  endtask

  task automatic test_excl();
    do_xfer(1'b1, 32'h40, 3'd2, 32'h1234_5678, 1'b0);
    do_xfer(1'b0, 32'h40, 3'd2, 32'h0, 1'b1);
    do_xfer(1'b1, 32'h40, 3'd2, 32'hAAAA_5555, 1'b1);
    do_xfer(1'b1, 32'h40, 3'd2, 32'h5555_AAAA, 1'b1);
    do_xfer(1'b0, 32'h40, 3'd2, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    sel0 = 1'b1; trans0 = 2'b10; write0 = 1'b1; addr0 = 32'h0;
    @(posedge hclk); #1;
    addr0 = 32'h4; wdata0 = 32'h0123_4567;
    @(negedge hclk);
    n_cmp++; if (ready0 !== 1'b1 || resp0 !== 2'b00) begin n_bad++; $display("FAIL b2b_w0 got %b/%b want 1/00", ready0, resp0); end
    @(posedge hclk); #1;
    write0 = 1'b0; addr0 = 32'h4; wdata0 = 32'h89AB_CDEF; sb0.push_back(32'h89AB_CDEF);
    @(negedge hclk);
    n_cmp++; if (ready0 !== 1'b1 || resp0 !== 2'b00) begin n_bad++; $display("FAIL b2b_w4 got %b/%b want 1/00", ready0, resp0); end
    @(posedge hclk); #1;
    addr0 = 32'h0; wdata0 = 32'h0; sb0.push_back(32'h0123_4567);
    @(negedge hclk);
    want = sb0.pop_front();
    n_cmp++; if (ready0 !== 1'b1 || rdata0 !== want) begin n_bad++; $display("FAIL b2b_r4 got %b/%h want 1/%h", ready0, rdata0, want); end
    @(posedge hclk); #1;
    sel0 = 1'b0; trans0 = 2'b00;
    @(negedge hclk);
    want = sb0.pop_front();
    n_cmp++; if (ready0 !== 1'b1 || rdata0 !== want) begin n_bad++; $display("FAIL b2b_r0 got %b/%h want 1/%h", ready0, rdata0, want); end
    n_cmp++; if (exok0 !== 1'b0) begin n_bad++; $display("FAIL b2b_exok got %b want 0", exok0); end
    @(posedge hclk); #1;
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_idle_busy();
    test_illegal();
    test_hready_low();
    test_reset_abort();
    test_excl();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
